ingress_admit: RTL and testbench

Per-port ingress admission stage. It sits between the port interface pins (valid_in/source_in/target_in/data_in) and the write side of the switch_port input FIFO. It legality-checks each header and holds one packet in a capture register while the FIFO is full, retrying for a bounded time. It keeps saturating statistics counters: accepted, dropped-full and dropped-illegal packets. One instance per port.

---
 rtl/packet_pkg.sv | 30 +++
 rtl/sat_counter.sv | 27 ++
 rtl/ingress_admit.sv | 116 +++++++++++
 tb/tb_ingress_admit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/packet_pkg.sv
// rtl/packet_pkg.sv - shared packet layout, capture states and header legality check
package packet_pkg;

    localparam int NUM_PORTS    = 4;
    localparam int SRC_LSB      = 0;
    localparam int TGT_LSB      = 4;
    localparam int DATA_LSB     = 8;
    localparam int HDR_W        = 8;
    localparam int DATA_W_DEF   = 8;
    localparam int PACKET_WIDTH = HDR_W + DATA_W_DEF;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [3:0]            target;
        logic [3:0]            source;
    } pkt_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } cap_state_t;

    // Source must be exactly this port's one-hot bit and at least one target must be set.
    function automatic logic is_legal(input logic [3:0] src, input logic [3:0] tgt, input int port_id);
        logic [3:0] w_exp_src;
        w_exp_src = 4'(1 << port_id);
        return (src == w_exp_src) && (tgt != 4'b0000);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Clear beats a coincident increment; the event is intentionally lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/ingress_admit.sv
// rtl/ingress_admit.sv - per-port header check, single-packet capture with bounded retry, statistics
module ingress_admit
    import packet_pkg::*;
#(
    parameter int PORT_ID   = 0,
    parameter int RETRY_MAX = 4,
    parameter int CNT_W     = 16,
    parameter int DATA_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [3:0]            source_in,
    input  logic [3:0]            target_in,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [HDR_W+DATA_W-1:0] fifo_din,
    input  logic                  cnt_clr,
    output logic                  busy,
    output logic [CNT_W-1:0]      accept_cnt,
    output logic [CNT_W-1:0]      drop_full_cnt,
    output logic [CNT_W-1:0]      drop_bad_cnt
);

    localparam int WAIT_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

    cap_state_t               r_state;
    cap_state_t               w_next_state;
    logic [HDR_W+DATA_W-1:0]  r_pkt;
    logic [WAIT_W-1:0]        r_wait;

    logic w_cap_v;
    logic w_legal;
    logic w_bad;
    logic w_wr;
    logic w_timeout;
    logic w_free;
    logic w_capture;
    logic w_drop_new;
    logic w_drop_full_inc;

    assign w_cap_v    = (r_state == ST_HELD);
    assign w_legal    = valid_in && is_legal(source_in, target_in, PORT_ID);
    assign w_bad      = valid_in && !is_legal(source_in, target_in, PORT_ID);
    assign w_wr       = w_cap_v && !fifo_full;
    assign w_timeout  = w_cap_v && fifo_full && (r_wait == WAIT_W'(RETRY_MAX));
    assign w_free     = !w_cap_v || w_wr || w_timeout;
    assign w_capture  = w_legal && w_free;
    assign w_drop_new = w_legal && !w_free;
    // Timeout implies free, so at most one of these fires per cycle.
    assign w_drop_full_inc = w_drop_new || w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_capture) begin
            w_next_state = ST_HELD;
        end else if (w_wr || w_timeout) begin
            w_next_state = ST_EMPTY;
        end
    end

    always_comb begin
        fifo_wr_en = w_wr;
        busy       = w_cap_v;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt  <= '0;
            r_wait <= '0;
        end else if (w_capture) begin
            r_pkt  <= {data_in, target_in, source_in};
            r_wait <= '0;
        end else if (w_wr || w_timeout) begin
            r_wait <= '0;
        end else if (w_cap_v && fifo_full) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    assign fifo_din = r_pkt;

    sat_counter #(.CNT_W(CNT_W)) u_accept_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_wr),
        .clr (cnt_clr),
        .cnt (accept_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_drop_full_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_drop_full_inc),
        .clr (cnt_clr),
        .cnt (drop_full_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_drop_bad_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_bad),
        .clr (cnt_clr),
        .cnt (drop_bad_cnt)
    );

endmodule

// File: tb/tb_ingress_admit.sv
// tb/tb_ingress_admit.sv - scoreboard bench for ingress_admit (PORT_ID=0, RETRY_MAX=4, CNT_W=4)
module tb_ingress_admit;

    localparam int CNT_W  = 4;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              valid_in = 1'b0;
    logic [3:0]        source_in = '0;
    logic [3:0]        target_in = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic              fifo_full = 1'b0;
    logic              fifo_wr_en;
    logic [15:0]       fifo_din;
    logic              cnt_clr = 1'b0;
    logic              busy;
    logic [CNT_W-1:0]  accept_cnt;
    logic [CNT_W-1:0]  drop_full_cnt;
    logic [CNT_W-1:0]  drop_bad_cnt;

    int n_vec = 0;
    int n_err = 0;
    int wr_count = 0;
    logic [15:0] exp_q[$];

    ingress_admit #(
        .PORT_ID   (0),
        .RETRY_MAX (4),
        .CNT_W     (CNT_W),
        .DATA_W    (DATA_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .source_in     (source_in),
        .target_in     (target_in),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_din      (fifo_din),
        .cnt_clr       (cnt_clr),
        .busy          (busy),
        .accept_cnt    (accept_cnt),
        .drop_full_cnt (drop_full_cnt),
        .drop_bad_cnt  (drop_bad_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] src, input logic [3:0] tgt, input logic [7:0] data, input bit expect_wr);
        valid_in  = 1'b1;
        source_in = src;
        target_in = tgt;
        data_in   = data;
        if (expect_wr) exp_q.push_back({data, tgt, src});
        tick();
        valid_in = 1'b0;
    endtask

    task automatic clear_counters();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (fifo_wr_en) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", 32'(fifo_wr_en), 32'd0);
            end else begin
                chk("fifo_din", 32'(fifo_din), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_din", 32'(fifo_din), 32'd0);
        chk("rst_accept", 32'(accept_cnt), 32'd0);
        chk("rst_drop_full", 32'(drop_full_cnt), 32'd0);
        chk("rst_drop_bad", 32'(drop_bad_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // streaming: 10 back-to-back legal packets
        wr_count = 0;
        for (int i = 0; i < 10; i++) send(4'b0001, 4'b0110, 8'(i), 1'b1);
        tick();
        tick();
        chk("stream_wr_count", 32'(wr_count), 32'd10);
        chk("stream_accept", 32'(accept_cnt), 32'd10);
        chk("stream_drop_full", 32'(drop_full_cnt), 32'd0);
        chk("stream_drop_bad", 32'(drop_bad_cnt), 32'd0);
        chk("stream_q_empty", 32'(exp_q.size()), 32'd0);

        // illegal headers
        clear_counters();
        chk("clr_accept", 32'(accept_cnt), 32'd0);
        wr_count = 0;
        send(4'b0010, 4'b0001, 8'h11, 1'b0);
        chk("bad1_busy", 32'(busy), 32'd0);
        send(4'b0001, 4'b0000, 8'h22, 1'b0);
        chk("bad2_busy", 32'(busy), 32'd0);
        tick();
        chk("bad_cnt", 32'(drop_bad_cnt), 32'd2);
        chk("bad_wr_count", 32'(wr_count), 32'd0);

        // hold and release after 3 full cycles
        clear_counters();
        fifo_full = 1'b1;
        send(4'b0001, 4'b1000, 8'hA5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("hold_busy", 32'(busy), 32'd1);
            chk("hold_din", 32'(fifo_din), 32'hA581);
            tick();
        end
        fifo_full = 1'b0;
        #1;
        chk("rel_busy", 32'(busy), 32'd1);
        chk("rel_wr_en", 32'(fifo_wr_en), 32'd1);
        tick();
        chk("rel_busy_after", 32'(busy), 32'd0);
        chk("rel_accept", 32'(accept_cnt), 32'd1);
        chk("rel_drop_full", 32'(drop_full_cnt), 32'd0);

        // timeout plus collision
        clear_counters();
        fifo_full = 1'b1;
        send(4'b0001, 4'b0010, 8'hA0, 1'b0);
        tick();
        send(4'b0001, 4'b0010, 8'hB0, 1'b0);
        tick();
        tick();
        send(4'b0001, 4'b0100, 8'hC0, 1'b1);
        chk("to_drop_full", 32'(drop_full_cnt), 32'd2);
        chk("to_busy", 32'(busy), 32'd1);
        chk("to_din", 32'(fifo_din), 32'hC041);
        fifo_full = 1'b0;
        tick();
        chk("to_accept", 32'(accept_cnt), 32'd1);
        chk("to_busy_after", 32'(busy), 32'd0);

        // reset mid-hold
        fifo_full = 1'b1;
        send(4'b0001, 4'b1111, 8'hDD, 1'b0);
        chk("mh_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mh_rst_busy", 32'(busy), 32'd0);
        chk("mh_rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("mh_rst_accept", 32'(accept_cnt), 32'd0);
        chk("mh_rst_drop_full", 32'(drop_full_cnt), 32'd0);
        tick();
        rst = 1'b0;
        fifo_full = 1'b0;
        wr_count = 0;
        tick();
        tick();
        chk("mh_no_write", 32'(wr_count), 32'd0);
        chk("mh_accept", 32'(accept_cnt), 32'd0);

        // saturation, then clear coincident with a write
        for (int i = 0; i < 17; i++) send(4'b0001, 4'b0011, 8'(8'h40 + i), 1'b1);
        tick();
        tick();
        chk("sat_accept", 32'(accept_cnt), 32'd15);
        send(4'b0001, 4'b0011, 8'h77, 1'b1);
        cnt_clr = 1'b1;
        #1;
        chk("clrwr_wr_en", 32'(fifo_wr_en), 32'd1);
        tick();
        cnt_clr = 1'b0;
        chk("clrwr_accept", 32'(accept_cnt), 32'd0);
        tick();
        chk("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
